// File: rtl/ifft_8p.sv
// rtl/ifft_8p.sv - 8-point radix-2 DIT inverse FFT, one time-shared butterfly, streamed output
module ifft_8p #(
  parameter int N = 8,
  parameter int W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] X0r,
  input  logic signed [W-1:0] X1r,
  input  logic signed [W-1:0] X2r,
  input  logic signed [W-1:0] X3r,
  input  logic signed [W-1:0] X4r,
  input  logic signed [W-1:0] X5r,
  input  logic signed [W-1:0] X6r,
  input  logic signed [W-1:0] X7r,
  input  logic signed [W-1:0] X0i,
  input  logic signed [W-1:0] X1i,
  input  logic signed [W-1:0] X2i,
  input  logic signed [W-1:0] X3i,
  input  logic signed [W-1:0] X4i,
  input  logic signed [W-1:0] X5i,
  input  logic signed [W-1:0] X6i,
  input  logic signed [W-1:0] X7i,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2:0]          out_idx,
  output logic signed [W-1:0] out_r,
  output logic signed [W-1:0] out_i
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_OUT} state_t;

  state_t                state_q, state_d;
  logic [3:0]            step_q, step_d;
  logic                  out_valid_q, out_valid_d;
  logic [2:0]            out_idx_q, out_idx_d;
  logic signed [W-1:0]   out_r_q, out_r_d;
  logic signed [W-1:0]   out_i_q, out_i_d;
  logic signed [W-1:0]   mem_r_q [N];
  logic signed [W-1:0]   mem_i_q [N];
  logic signed [W-1:0]   mem_r_d [N];
  logic signed [W-1:0]   mem_i_d [N];

  logic [2:0]            bf_a, bf_b;
  logic [1:0]            bf_k;
  logic signed [W-1:0]   a_r, a_i, b_r, b_i;
  logic signed [32:0]    br_x, bi_x, wr_x, wi_x;
  logic signed [32:0]    prod_r, prod_i;
  logic signed [16:0]    t_r, t_i;
  logic signed [17:0]    sum0_r, sum0_i, sum1_r, sum1_i;
  logic signed [W-1:0]   y0_r, y0_i, y1_r, y1_i;
  logic                  unused_prod;

  // Halve an 18-bit butterfly sum (floor) and clamp it to Q1.15.
  function automatic logic signed [15:0] sat_half(input logic signed [17:0] s);
    logic signed [17:0] h;
    h = s >>> 1;
    if (h > 18'sd32767)       return 16'sh7fff;
    else if (h < -18'sd32768) return 16'sh8000;
    else                      return h[15:0];
  endfunction

  // Fixed butterfly schedule: memory pair (a,b) and conjugate twiddle index per step.
  always_comb begin
    bf_a = 3'd0;
    bf_b = 3'd1;
    bf_k = 2'd0;
    case (step_q)
      4'd0:  begin bf_a = 3'd0; bf_b = 3'd1; bf_k = 2'd0; end
      4'd1:  begin bf_a = 3'd2; bf_b = 3'd3; bf_k = 2'd0; end
      4'd2:  begin bf_a = 3'd4; bf_b = 3'd5; bf_k = 2'd0; end
      4'd3:  begin bf_a = 3'd6; bf_b = 3'd7; bf_k = 2'd0; end
      4'd4:  begin bf_a = 3'd0; bf_b = 3'd2; bf_k = 2'd0; end
      4'd5:  begin bf_a = 3'd1; bf_b = 3'd3; bf_k = 2'd2; end
      4'd6:  begin bf_a = 3'd4; bf_b = 3'd6; bf_k = 2'd0; end
      4'd7:  begin bf_a = 3'd5; bf_b = 3'd7; bf_k = 2'd2; end
      4'd8:  begin bf_a = 3'd0; bf_b = 3'd4; bf_k = 2'd0; end
      4'd9:  begin bf_a = 3'd1; bf_b = 3'd5; bf_k = 2'd1; end
      4'd10: begin bf_a = 3'd2; bf_b = 3'd6; bf_k = 2'd2; end
      4'd11: begin bf_a = 3'd3; bf_b = 3'd7; bf_k = 2'd3; end
      default: begin bf_a = 3'd0; bf_b = 3'd1; bf_k = 2'd0; end
    endcase
  end

  // Butterfly datapath: twiddle b (exact for k=0/2, multiplied for k=1/3), then halved sum/difference.
  always_comb begin
    a_r  = mem_r_q[bf_a];
    a_i  = mem_i_q[bf_a];
    b_r  = mem_r_q[bf_b];
    b_i  = mem_i_q[bf_b];
    br_x = {{17{b_r[15]}}, b_r};
    bi_x = {{17{b_i[15]}}, b_i};
    wi_x = 33'sd23170;
    wr_x = (bf_k == 2'd1) ? 33'sd23170 : -33'sd23170;
    prod_r = (br_x * wr_x) - (bi_x * wi_x);
    prod_i = (br_x * wi_x) + (bi_x * wr_x);
    case (bf_k)
      2'd0: begin
        t_r = {b_r[15], b_r};
        t_i = {b_i[15], b_i};
      end
      2'd2: begin
        t_r = -{b_i[15], b_i};
        t_i = {b_r[15], b_r};
      end
      default: begin
        t_r = prod_r[31:15];
        t_i = prod_i[31:15];
      end
    endcase
    sum0_r = {{2{a_r[15]}}, a_r} + {t_r[16], t_r};
    sum0_i = {{2{a_i[15]}}, a_i} + {t_i[16], t_i};
    sum1_r = {{2{a_r[15]}}, a_r} - {t_r[16], t_r};
    sum1_i = {{2{a_i[15]}}, a_i} - {t_i[16], t_i};
    y0_r = sat_half(sum0_r);
    y0_i = sat_half(sum0_i);
    y1_r = sat_half(sum1_r);
    y1_i = sat_half(sum1_i);
  end

  // Product bits outside the Q1.15 window carry no information after the shift.
  assign unused_prod = ^{prod_r[32], prod_r[14:0], prod_i[32], prod_i[14:0]};

  // Next-state: accept a bin set in bit-reversed order, run 12 butterflies, then stream 8 samples.
  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_r_d     = out_r_q;
    out_i_d     = out_i_q;
    mem_r_d     = mem_r_q;
    mem_i_d     = mem_i_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          mem_r_d[0] = X0r; mem_i_d[0] = X0i;
          mem_r_d[1] = X4r; mem_i_d[1] = X4i;
          mem_r_d[2] = X2r; mem_i_d[2] = X2i;
          mem_r_d[3] = X6r; mem_i_d[3] = X6i;
          mem_r_d[4] = X1r; mem_i_d[4] = X1i;
          mem_r_d[5] = X5r; mem_i_d[5] = X5i;
          mem_r_d[6] = X3r; mem_i_d[6] = X3i;
          mem_r_d[7] = X7r; mem_i_d[7] = X7i;
          step_d  = 4'd0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        mem_r_d[bf_a] = y0_r;
        mem_i_d[bf_a] = y0_i;
        mem_r_d[bf_b] = y1_r;
        mem_i_d[bf_b] = y1_i;
        if (step_q == 4'd11) begin
          // The last butterfly touches only m[3]/m[7], so m[0] is already final here.
          state_d     = S_OUT;
          out_valid_d = 1'b1;
          out_idx_d   = 3'd0;
          out_r_d     = mem_r_q[0];
          out_i_d     = mem_i_q[0];
        end else begin
          step_d = step_q + 4'd1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          if (out_idx_q == 3'd7) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_idx_d   = 3'd0;
            out_r_d     = '0;
            out_i_d     = '0;
          end else begin
            out_idx_d = out_idx_q + 3'd1;
            out_r_d   = mem_r_q[out_idx_q + 3'd1];
            out_i_d   = mem_i_q[out_idx_q + 3'd1];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and output registers; an asynchronous reset abandons any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      step_q      <= 4'd0;
      out_valid_q <= 1'b0;
      out_idx_q   <= 3'd0;
      out_r_q     <= '0;
      out_i_q     <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_r_q     <= out_r_d;
      out_i_q     <= out_i_d;
    end
  end

  // Working memory needs no reset: it is fully rewritten on every accept.
  always_ff @(posedge clk) begin
    mem_r_q <= mem_r_d;
    mem_i_q <= mem_i_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_r     = out_r_q;
  assign out_i     = out_i_q;

endmodule

// File: tb/tb_ifft_8p.sv
// tb/tb_ifft_8p.sv - self-checking bench for ifft_8p against a direct-form IFFT model
module tb_ifft_8p;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rst_n, in_valid, in_ready, out_valid, out_ready;
  logic signed [15:0] xr [8];
  logic signed [15:0] xi [8];
  logic [2:0]         out_idx;
  logic signed [15:0] out_r, out_i;

  int n_checks = 0;
  int n_pass   = 0;
  int fr [8], fi [8], er [8], ei [8];
  int cyc;
  bit quiet;

  ifft_8p #(.N(8), .W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .X0r(xr[0]), .X1r(xr[1]), .X2r(xr[2]), .X3r(xr[3]),
    .X4r(xr[4]), .X5r(xr[5]), .X6r(xr[6]), .X7r(xr[7]),
    .X0i(xi[0]), .X1i(xi[1]), .X2i(xi[2]), .X3i(xi[3]),
    .X4i(xi[4]), .X5i(xi[5]), .X6i(xi[6]), .X7i(xi[7]),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_r(out_r), .out_i(out_i)
  );

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int bitrev3(input int k);
    return (k & 1) * 4 + ((k >> 1) & 1) * 2 + ((k >> 2) & 1);
  endfunction

  function automatic longint sat_half(input longint v);
    longint h;
    h = v >>> 1;
    if (h > 32767) return 32767;
    if (h < -32768) return -32768;
    return h;
  endfunction

  // In-place radix-2 DIT over bit-reversed input, twiddle e^{+j2*pi*k/8}, halving per stage.
  function automatic void model();
    longint mr [8], mi [8];
    longint ar, ai, br, bi, tr, ti, wr, wi;
    int span, a, b, k;
    for (int n = 0; n < 8; n++) begin
      mr[bitrev3(n)] = fr[n];
      mi[bitrev3(n)] = fi[n];
    end
    for (int s = 0; s < 3; s++) begin
      span = 1 << s;
      for (int base = 0; base < 8; base += 2 * span) begin
        for (int j = 0; j < span; j++) begin
          a = base + j; b = a + span; k = j * (4 >> s);
          ar = mr[a]; ai = mi[a]; br = mr[b]; bi = mi[b];
          if (k == 0) begin tr = br; ti = bi; end
          else if (k == 2) begin tr = -bi; ti = br; end
          else begin
            wr = (k == 1) ? 23170 : -23170;
            wi = 23170;
            tr = (br * wr - bi * wi) >>> 15;
            ti = (br * wi + bi * wr) >>> 15;
          end
          mr[a] = sat_half(ar + tr); mi[a] = sat_half(ai + ti);
          mr[b] = sat_half(ar - tr); mi[b] = sat_half(ai - ti);
        end
      end
    end
    for (int n = 0; n < 8; n++) begin
      er[n] = int'(mr[n]);
      ei[n] = int'(mi[n]);
    end
  endfunction

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0: return -32768;
      1: return 32767;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  // Starts at a negedge; ends at the negedge after the n=7 sample is taken.
  // ready_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random.
  task automatic run_frame(input int ready_mode, input bit hold_valid);
    int  c, got, ph;
    bit  busy_ok, held_ok, gap_ok, stalled, rdy;
    logic [2:0]         p_idx;
    logic signed [15:0] p_r, p_i;
    c = 0;
    while (!in_ready && c < 50) begin @(negedge clk); c++; end
    check("in_ready_idle", in_ready, 1);
    for (int n = 0; n < 8; n++) begin xr[n] = 16'(fr[n]); xi[n] = 16'(fi[n]); end
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_valid) in_valid = 1'b0;
    busy_ok = 1'b1;
    c = 1;
    while (!out_valid && c < 40) begin
      if (in_ready) busy_ok = 1'b0;
      for (int n = 0; n < 8; n++) begin xr[n] = 16'($urandom); xi[n] = 16'($urandom); end
      @(negedge clk);
      c++;
    end
    check("latency_cycle", c, 13);
    got = 0; ph = 0; stalled = 1'b0; held_ok = 1'b1; gap_ok = 1'b1; c = 0;
    p_idx = '0; p_r = '0; p_i = '0;
    while (got < 8 && c < 200) begin
      if (in_ready) busy_ok = 1'b0;
      if (stalled && !(out_valid === 1'b1 && out_idx === p_idx && out_r === p_r && out_i === p_i))
        held_ok = 1'b0;
      if (out_valid) begin
        case (ready_mode)
          0: rdy = 1'b1;
          1: rdy = ((ph % 4) == 0) || ((ph % 4) == 3);
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        ph++;
        out_ready = rdy;
        if (rdy) begin
          check("out_idx", out_idx, got);
          check("out_r", out_r, er[got]);
          check("out_i", out_i, ei[got]);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          p_idx = out_idx; p_r = out_r; p_i = out_i;
        end
      end else begin
        gap_ok = 1'b0;
      end
      @(negedge clk);
      c++;
    end
    out_ready = 1'b1;
    check("samples_taken", got, 8);
    check("no_valid_gap", gap_ok, 1);
    check("held_while_stalled", held_ok, 1);
    check("in_ready_low_busy", busy_ok, 1);
    check("end_out_valid", out_valid, 0);
    check("end_in_ready", in_ready, 1);
    check("end_out_idx", out_idx, 0);
  endtask

  task automatic set_impulse();
    for (int n = 0; n < 8; n++) begin fr[n] = 0; fi[n] = 0; er[n] = 1000; ei[n] = 0; end
    fr[0] = 8000;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 8; n++) begin xr[n] = '0; xi[n] = '0; end
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_r", out_r, 0);
    check("rst_out_i", out_i, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    set_impulse();
    run_frame(0, 1'b0);

    for (int n = 0; n < 8; n++) begin fr[n] = 8000; fi[n] = 0; er[n] = 0; ei[n] = 0; end
    er[0] = 8000;
    run_frame(0, 1'b0);

    for (int n = 0; n < 8; n++) begin fr[n] = 0; fi[n] = 0; end
    fr[1] = 8000;
    model();
    er[0] = 1000;  ei[0] = 0;
    er[2] = 0;     ei[2] = 1000;
    er[4] = -1000; ei[4] = 0;
    er[6] = 0;     ei[6] = -1000;
    run_frame(0, 1'b0);

    for (int n = 0; n < 8; n++) begin fr[n] = rnd_val(); fi[n] = rnd_val(); end
    model();
    run_frame(1, 1'b0);

    set_impulse();
    for (int n = 0; n < 8; n++) begin xr[n] = 16'(fr[n]); xi[n] = 16'(fi[n]); end
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("calc_in_ready_low", in_ready, 0);
    rst_n = 1'b0;
    #1;
    check("rst_calc_in_ready", in_ready, 1);
    check("rst_calc_out_valid", out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 40) begin @(negedge clk); cyc++; end
    check("pre_rst_out_r", out_r, 1000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("pre_rst_out_idx", out_idx, 1);
    rst_n = 1'b0;
    #1;
    check("rst_out_in_ready", in_ready, 1);
    check("rst_out_out_valid", out_valid, 0);
    check("rst_out_out_idx", out_idx, 0);
    check("rst_out_out_r", out_r, 0);
    check("rst_out_out_i", out_i, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    quiet = 1'b1;
    repeat (20) begin @(negedge clk); if (out_valid !== 1'b0) quiet = 1'b0; end
    check("no_emit_after_rst", quiet, 1);

    set_impulse();
    run_frame(0, 1'b0);

    for (int f = 0; f < 200; f++) begin
      for (int n = 0; n < 8; n++) begin fr[n] = rnd_val(); fi[n] = rnd_val(); end
      model();
      run_frame(2, 1'b1);
    end
    in_valid = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
